// File: rtl/mem_stage_if.sv
// Data-memory request/response bus between the MEM stage (master) and data memory (slave).
// A request transfers on a rising edge where dreq_valid && dreq_ready; the master holds every dreq_* field stable until then, and a load response is a single drsp_valid pulse.
interface mem_stage_if;
    logic        dreq_valid;
    logic        dreq_ready;
    logic        dreq_we;
    logic [31:0] dreq_addr;
    logic [3:0]  dreq_wstrb;
    logic [31:0] dreq_wdata;
    logic        drsp_valid;
    logic [31:0] drsp_rdata;

    modport master (
        output dreq_valid, dreq_we, dreq_addr, dreq_wstrb, dreq_wdata,
        input  dreq_ready, drsp_valid, drsp_rdata
    );

    modport slave (
        input  dreq_valid, dreq_we, dreq_addr, dreq_wstrb, dreq_wdata,
        output dreq_ready, drsp_valid, drsp_rdata
    );
endinterface

// File: rtl/mem_stage.sv
// Pipeline MEM stage: passes ALU results through, issues aligned loads/stores to data memory,
// aligns load data and flags misaligned accesses.
module mem_stage #(
    parameter int                 ALUOP_W = 8,
    parameter logic [ALUOP_W-1:0] OP_LD_B  = 8'h28,
    parameter logic [ALUOP_W-1:0] OP_LD_H  = 8'h29,
    parameter logic [ALUOP_W-1:0] OP_LD_W  = 8'h2A,
    parameter logic [ALUOP_W-1:0] OP_ST_B  = 8'h2B,
    parameter logic [ALUOP_W-1:0] OP_ST_H  = 8'h2C,
    parameter logic [ALUOP_W-1:0] OP_ST_W  = 8'h2D,
    parameter logic [ALUOP_W-1:0] OP_LD_BU = 8'h2E,
    parameter logic [ALUOP_W-1:0] OP_LD_HU = 8'h2F
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [31:0]        in_pc,
    input  logic [ALUOP_W-1:0] in_aluop,
    input  logic [4:0]         in_wd,
    input  logic               in_wreg,
    input  logic [31:0]        in_wdata,
    input  logic [31:0]        in_mem_addr,
    input  logic [31:0]        in_reg2,
    output logic               stall_req,
    mem_stage_if.master        dmem,
    output logic               wb_valid,
    output logic [31:0]        wb_pc,
    output logic [4:0]         wb_wd,
    output logic               wb_wreg,
    output logic [31:0]        wb_wdata,
    output logic               wb_ale,
    output logic [1:0]         dbg_state
);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_WAIT = 2'd2} state_t;

    state_t             state, state_nx;
    logic               stall_raw;
    logic               in_is_mem, in_is_store, in_mis;
    logic [31:0]        cap_pc, cap_addr, cap_reg2;
    logic [ALUOP_W-1:0] cap_aluop;
    logic [4:0]         cap_wd;
    logic               cap_wreg, cap_store;
    logic [3:0]         req_wstrb;
    logic [31:0]        req_wdata, load_data;
    logic [7:0]         ld_byte;
    logic [15:0]        ld_half;

    always_comb begin
        in_is_store = (in_aluop == OP_ST_B) || (in_aluop == OP_ST_H) || (in_aluop == OP_ST_W);
        in_is_mem   = in_is_store || (in_aluop == OP_LD_B) || (in_aluop == OP_LD_H) ||
                      (in_aluop == OP_LD_W) || (in_aluop == OP_LD_BU) || (in_aluop == OP_LD_HU);
        in_mis      = (((in_aluop == OP_LD_H) || (in_aluop == OP_LD_HU) || (in_aluop == OP_ST_H))
                        && in_mem_addr[0]) ||
                      (((in_aluop == OP_LD_W) || (in_aluop == OP_ST_W)) && (in_mem_addr[1:0] != 2'b00));
        cap_store   = (cap_aluop == OP_ST_B) || (cap_aluop == OP_ST_H) || (cap_aluop == OP_ST_W);
    end

    always_comb begin
        req_wstrb = 4'b0000;
        req_wdata = 32'h0;
        if (cap_aluop == OP_ST_B) begin
            req_wstrb = 4'b0001 << cap_addr[1:0];
            req_wdata = {4{cap_reg2[7:0]}};
        end else if (cap_aluop == OP_ST_H) begin
            req_wstrb = 4'b0011 << {cap_addr[1], 1'b0};
            req_wdata = {2{cap_reg2[15:0]}};
        end else if (cap_aluop == OP_ST_W) begin
            req_wstrb = 4'b1111;
            req_wdata = cap_reg2;
        end
    end

    // Request fields read as zero outside REQ so the bus is quiet while idle or in reset.
    assign dmem.dreq_valid = (state == S_REQ);
    assign dmem.dreq_we    = (state == S_REQ) && cap_store;
    assign dmem.dreq_addr  = (state == S_REQ) ? {cap_addr[31:2], 2'b00} : 32'h0;
    assign dmem.dreq_wstrb = (state == S_REQ) ? req_wstrb : 4'b0000;
    assign dmem.dreq_wdata = (state == S_REQ) ? req_wdata : 32'h0;

    always_comb begin
        ld_byte   = dmem.drsp_rdata[{cap_addr[1:0], 3'b000} +: 8];
        ld_half   = dmem.drsp_rdata[{cap_addr[1], 4'b0000} +: 16];
        load_data = dmem.drsp_rdata;
        if (cap_aluop == OP_LD_B)       load_data = {{24{ld_byte[7]}}, ld_byte};
        else if (cap_aluop == OP_LD_BU) load_data = {24'h0, ld_byte};
        else if (cap_aluop == OP_LD_H)  load_data = {{16{ld_half[15]}}, ld_half};
        else if (cap_aluop == OP_LD_HU) load_data = {16'h0, ld_half};
    end

    always_comb begin
        state_nx  = state;
        stall_raw = 1'b0;
        case (state)
            S_IDLE: begin
                if (in_valid && in_is_mem && !in_mis) begin
                    stall_raw = 1'b1;
                    state_nx  = S_REQ;
                end
            end
            S_REQ: begin
                stall_raw = !(dmem.dreq_ready && cap_store);
                if (dmem.dreq_ready) state_nx = cap_store ? S_IDLE : S_WAIT;
            end
            S_WAIT: begin
                stall_raw = !dmem.drsp_valid;
                if (dmem.drsp_valid) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Reset forces stall low immediately even while an aligned memory op sits on in_*.
    assign stall_req = rst && stall_raw;
    assign dbg_state = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            cap_pc    <= 32'h0;
            cap_addr  <= 32'h0;
            cap_reg2  <= 32'h0;
            cap_aluop <= '0;
            cap_wd    <= 5'h0;
            cap_wreg  <= 1'b0;
            wb_valid  <= 1'b0;
            wb_pc     <= 32'h0;
            wb_wd     <= 5'h0;
            wb_wreg   <= 1'b0;
            wb_wdata  <= 32'h0;
            wb_ale    <= 1'b0;
        end else begin
            state  <= state_nx;
            wb_ale <= 1'b0;
            case (state)
                S_IDLE: begin
                    wb_valid <= 1'b0;
                    if (in_valid && !in_is_mem) begin
                        wb_valid <= 1'b1;
                        wb_pc    <= in_pc;
                        wb_wd    <= in_wd;
                        wb_wreg  <= in_wreg;
                        wb_wdata <= in_wdata;
                    end else if (in_valid && in_mis) begin
                        wb_valid <= 1'b1;
                        wb_pc    <= in_pc;
                        wb_wd    <= in_wd;
                        wb_wreg  <= 1'b0;
                        wb_ale   <= 1'b1;
                    end else if (in_valid) begin
                        cap_pc    <= in_pc;
                        cap_addr  <= in_mem_addr;
                        cap_reg2  <= in_reg2;
                        cap_aluop <= in_aluop;
                        cap_wd    <= in_wd;
                        cap_wreg  <= in_wreg;
                    end
                end
                S_REQ: begin
                    wb_valid <= 1'b0;
                    if (dmem.dreq_ready && cap_store) begin
                        wb_valid <= 1'b1;
                        wb_pc    <= cap_pc;
                        wb_wd    <= cap_wd;
                        wb_wreg  <= 1'b0;
                    end
                end
                S_WAIT: begin
                    wb_valid <= 1'b0;
                    if (dmem.drsp_valid) begin
                        wb_valid <= 1'b1;
                        wb_pc    <= cap_pc;
                        wb_wd    <= cap_wd;
                        wb_wreg  <= cap_wreg;
                        wb_wdata <= load_data;
                    end
                end
                default: wb_valid <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed plus randomized bench for mem_stage; a behavioural model derives the expected
// request fields, aligned load data and writeback values from access size and offset.
module tb_mem_stage;

    localparam logic [7:0] LD_B = 8'h28, LD_H = 8'h29, LD_W = 8'h2A, ST_B = 8'h2B;
    localparam logic [7:0] ST_H = 8'h2C, ST_W = 8'h2D, LD_BU = 8'h2E, LD_HU = 8'h2F;

    logic        clk, rst;
    logic        in_valid, in_wreg;
    logic [31:0] in_pc, in_wdata, in_mem_addr, in_reg2;
    logic [7:0]  in_aluop;
    logic [4:0]  in_wd;
    logic        stall_req, wb_valid, wb_wreg, wb_ale;
    logic [31:0] wb_pc, wb_wdata;
    logic [4:0]  wb_wd;
    logic [1:0]  dbg_state;
    int          total, bad;
    logic [31:0] last_pc;

    mem_stage_if dmem ();

    mem_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_pc(in_pc), .in_aluop(in_aluop),
        .in_wd(in_wd), .in_wreg(in_wreg), .in_wdata(in_wdata), .in_mem_addr(in_mem_addr),
        .in_reg2(in_reg2), .stall_req(stall_req), .dmem(dmem), .wb_valid(wb_valid),
        .wb_pc(wb_pc), .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata),
        .wb_ale(wb_ale), .dbg_state(dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit m_is_mem(input logic [7:0] op);
        return (op >= 8'h28) && (op <= 8'h2F);
    endfunction

    function automatic bit m_is_store(input logic [7:0] op);
        return (op == ST_B) || (op == ST_H) || (op == ST_W);
    endfunction

    function automatic int m_size(input logic [7:0] op);
        if (op == LD_B || op == LD_BU || op == ST_B) return 1;
        if (op == LD_H || op == LD_HU || op == ST_H) return 2;
        return 4;
    endfunction

    function automatic bit m_mis(input logic [7:0] op, input logic [31:0] addr);
        return (int'(addr[1:0]) % m_size(op)) != 0;
    endfunction

    function automatic logic [3:0] m_strb(input logic [7:0] op, input logic [31:0] addr);
        int sz, base;
        if (!m_is_store(op)) return 4'b0000;
        sz   = m_size(op);
        base = int'(addr[1:0]) - (int'(addr[1:0]) % sz);
        return 4'(((1 << sz) - 1) << base);
    endfunction

    function automatic logic [31:0] m_wdata(input logic [7:0] op, input logic [31:0] reg2);
        logic [31:0] w;
        int sz;
        w = 32'h0;
        if (!m_is_store(op)) return w;
        sz = m_size(op);
        for (int j = 0; j < 4; j++) w[8*j +: 8] = 8'(reg2 >> (8 * (j % sz)));
        return w;
    endfunction

    function automatic logic [31:0] m_load(input logic [7:0] op, input logic [31:0] addr,
                                           input logic [31:0] rdata);
        logic [31:0] v;
        if (m_size(op) == 4) return rdata;
        if (m_size(op) == 1) begin
            v = (rdata >> (8 * int'(addr[1:0]))) & 32'hFF;
            if (op == LD_B && v >= 32'd128) v = v + 32'hFFFF_FF00;
        end else begin
            v = (rdata >> (16 * int'(addr[1]))) & 32'hFFFF;
            if (op == LD_H && v >= 32'd32768) v = v + 32'hFFFF_0000;
        end
        return v;
    endfunction

    // ---------------- drivers ----------------
    task automatic idle_cycle;
        in_valid = 1'b0;
        tick;
        chk1("idle_wb_valid", wb_valid, 1'b0);
        chk1("idle_wb_ale", wb_ale, 1'b0);
        chk("idle_wb_pc_hold", wb_pc, last_pc);
    endtask

    task automatic run_op(input logic [7:0] op, input logic [31:0] pc, input logic [4:0] wd,
                          input logic wreg, input logic [31:0] wdata, input logic [31:0] addr,
                          input logic [31:0] reg2, input int rdly, input int sdly,
                          input logic [31:0] rdata);
        bit st;
        in_valid = 1'b1; in_pc = pc; in_aluop = op; in_wd = wd; in_wreg = wreg;
        in_wdata = wdata; in_mem_addr = addr; in_reg2 = reg2;
        dmem.dreq_ready = 1'b0; dmem.drsp_valid = 1'b0;
        last_pc = pc;
        #1;
        if (!m_is_mem(op)) begin
            chk1("np_stall", stall_req, 1'b0);
            chk1("np_dreq_valid", dmem.dreq_valid, 1'b0);
            tick;
            in_valid = 1'b0;
            chk1("np_wb_valid", wb_valid, 1'b1);
            chk("np_wb_pc", wb_pc, pc);
            chk("np_wb_wd", 32'(wb_wd), 32'(wd));
            chk1("np_wb_wreg", wb_wreg, wreg);
            chk("np_wb_wdata", wb_wdata, wdata);
            chk1("np_wb_ale", wb_ale, 1'b0);
        end else if (m_mis(op, addr)) begin
            chk1("ale_stall", stall_req, 1'b0);
            chk1("ale_dreq_valid", dmem.dreq_valid, 1'b0);
            tick;
            in_valid = 1'b0;
            chk1("ale_dreq_after", dmem.dreq_valid, 1'b0);
            chk1("ale_wb_valid", wb_valid, 1'b1);
            chk1("ale_wb_wreg", wb_wreg, 1'b0);
            chk1("ale_wb_ale", wb_ale, 1'b1);
            chk("ale_wb_pc", wb_pc, pc);
        end else begin
            st = m_is_store(op);
            chk1("acc_stall", stall_req, 1'b1);
            tick;
            for (int i = 0; i <= rdly; i++) begin
                dmem.dreq_ready = (i == rdly);
                dmem.drsp_valid = 1'($urandom_range(0, 1));
                dmem.drsp_rdata = $urandom;
                #1;
                chk1("req_valid", dmem.dreq_valid, 1'b1);
                chk1("req_we", dmem.dreq_we, st);
                chk("req_addr", dmem.dreq_addr, addr & 32'hFFFF_FFFC);
                chk("req_wstrb", 32'(dmem.dreq_wstrb), 32'(m_strb(op, addr)));
                chk("req_wdata", dmem.dreq_wdata, m_wdata(op, reg2));
                chk1("req_stall", stall_req, !((i == rdly) && st));
                chk1("req_wb_valid", wb_valid, 1'b0);
                tick;
            end
            dmem.dreq_ready = 1'b0;
            dmem.drsp_valid = 1'b0;
            if (st) begin
                in_valid = 1'b0;
                chk1("st_wb_valid", wb_valid, 1'b1);
                chk1("st_wb_wreg", wb_wreg, 1'b0);
                chk("st_wb_pc", wb_pc, pc);
                chk1("st_wb_ale", wb_ale, 1'b0);
            end else begin
                chk1("wait_dreq_valid", dmem.dreq_valid, 1'b0);
                chk1("wait_wb_valid0", wb_valid, 1'b0);
                for (int i = 0; i < sdly; i++) begin
                    #1;
                    chk1("wait_stall", stall_req, 1'b1);
                    tick;
                    chk1("wait_wb_valid", wb_valid, 1'b0);
                end
                dmem.drsp_valid = 1'b1;
                dmem.drsp_rdata = rdata;
                #1;
                chk1("rsp_stall", stall_req, 1'b0);
                tick;
                dmem.drsp_valid = 1'b0;
                in_valid = 1'b0;
                chk1("ld_wb_valid", wb_valid, 1'b1);
                chk("ld_wb_wdata", wb_wdata, m_load(op, addr, rdata));
                chk1("ld_wb_wreg", wb_wreg, wreg);
                chk("ld_wb_wd", 32'(wb_wd), 32'(wd));
                chk("ld_wb_pc", wb_pc, pc);
            end
        end
    endtask

    initial begin
        logic [7:0] op;
        int kind;
        total = 0; bad = 0; last_pc = 32'h0;
        rst = 1'b0; in_valid = 1'b0; in_pc = 32'h0; in_aluop = 8'h0; in_wd = 5'h0;
        in_wreg = 1'b0; in_wdata = 32'h0; in_mem_addr = 32'h0; in_reg2 = 32'h0;
        dmem.dreq_ready = 1'b0; dmem.drsp_valid = 1'b0; dmem.drsp_rdata = 32'h0;
        #2;
        chk1("rst_wb_valid", wb_valid, 1'b0);
        chk1("rst_stall", stall_req, 1'b0);
        chk1("rst_dreq_valid", dmem.dreq_valid, 1'b0);
        chk("rst_wb_pc", wb_pc, 32'h0);
        chk("rst_wb_wdata", wb_wdata, 32'h0);
        chk1("rst_wb_ale", wb_ale, 1'b0);
        tick;
        tick;
        rst = 1'b1;

        // directed cases
        run_op(8'h01, 32'h1C00_0000, 5'd5, 1'b1, 32'h0000_1234, 32'h0, 32'h0, 0, 0, 32'h0);
        run_op(ST_B, 32'h1C00_0004, 5'd0, 1'b0, 32'h0, 32'h0000_0103, 32'h0000_00AB, 2, 0, 32'h0);
        run_op(LD_B, 32'h1C00_0008, 5'd7, 1'b1, 32'h0, 32'h0000_0102, 32'h0, 0, 3, 32'h0080_0000);
        run_op(LD_BU, 32'h1C00_000C, 5'd8, 1'b1, 32'h0, 32'h0000_0102, 32'h0, 1, 3, 32'h0080_0000);
        run_op(LD_W, 32'h1C00_0010, 5'd9, 1'b1, 32'h0, 32'h0000_0102, 32'h0, 0, 0, 32'h0);
        idle_cycle();
        run_op(ST_H, 32'h1C00_0014, 5'd0, 1'b0, 32'h0, 32'h0000_0202, 32'h1234_BEEF, 0, 0, 32'h0);
        run_op(LD_H, 32'h1C00_0018, 5'd3, 1'b1, 32'h0, 32'h0000_0202, 32'h0, 0, 0, 32'h8001_7FFF);
        run_op(LD_HU, 32'h1C00_001C, 5'd4, 1'b1, 32'h0, 32'h0000_0200, 32'h0, 2, 1, 32'h1234_8765);
        run_op(ST_W, 32'h1C00_0020, 5'd0, 1'b0, 32'h0, 32'h0000_0300, 32'hCAFE_F00D, 1, 0, 32'h0);
        run_op(ST_H, 32'h1C00_0024, 5'd0, 1'b0, 32'h0, 32'h0000_0301, 32'h0, 0, 0, 32'h0);

        // reset while a load waits for its response
        in_valid = 1'b1; in_pc = 32'h1C00_0028; in_aluop = LD_W; in_wd = 5'd2; in_wreg = 1'b1;
        in_mem_addr = 32'h0000_0400; last_pc = 32'h0;
        tick;
        dmem.dreq_ready = 1'b1;
        tick;
        dmem.dreq_ready = 1'b0;
        tick;
        #3;
        rst = 1'b0;
        #1;
        chk1("midrst_stall", stall_req, 1'b0);
        chk1("midrst_dreq_valid", dmem.dreq_valid, 1'b0);
        chk1("midrst_wb_valid", wb_valid, 1'b0);
        chk("midrst_wb_pc", wb_pc, 32'h0);
        chk1("midrst_wb_ale", wb_ale, 1'b0);
        in_valid = 1'b0;
        #1;
        rst = 1'b1;
        tick;
        dmem.drsp_valid = 1'b1;
        dmem.drsp_rdata = 32'hDEAD_BEEF;
        #1;
        chk1("late_rsp_stall", stall_req, 1'b0);
        tick;
        dmem.drsp_valid = 1'b0;
        chk1("late_rsp_wb_valid", wb_valid, 1'b0);
        chk("late_rsp_wb_wdata", wb_wdata, 32'h0);
        run_op(LD_W, 32'h1C00_002C, 5'd6, 1'b1, 32'h0, 32'h0000_0404, 32'h0, 0, 1, 32'h5A5A_1234);

        // randomized traffic
        for (int n = 0; n < 60; n++) begin
            kind = $urandom_range(0, 3);
            if (kind == 3) begin
                idle_cycle();
            end else begin
                if (kind == 0) begin
                    do op = 8'($urandom_range(0, 255)); while (m_is_mem(op));
                end else begin
                    op = 8'($urandom_range(8'h28, 8'h2F));
                end
                run_op(op, $urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                       $urandom, $urandom, $urandom, $urandom_range(0, 3),
                       $urandom_range(0, 3), $urandom);
            end
        end
        idle_cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter ALUOP_W, default 8, width of aluop field.
REQ-002 Parameters OP_LD_B/LD_H/LD_W/ST_B/ST_H/ST_W/LD_BU/LD_HU, defaults 8'h28/29/2A/2B/2C/2D/2E/2F, memory-op encodings; any other aluop is a non-memory op.
REQ-003 clk  in  1  sole clock, rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 in_valid  in  1  instruction from EX/MEM register valid.
REQ-006 in_pc  in  32  instruction PC.
REQ-007 in_aluop  in  ALUOP_W  operation code.
REQ-008 in_wd / in_wreg / in_wdata  in  5/1/32  dest reg, write enable, ALU result.
REQ-009 in_mem_addr / in_reg2  in  32/32  effective address, store data.
REQ-010 stall_req  out  1  upstream SHALL hold all in_* while high.
REQ-011 dreq_valid/dreq_ready  out/in  1/1  data-memory request handshake.
REQ-012 dreq_we / dreq_addr / dreq_wstrb / dreq_wdata  out  1/32/4/32  write flag, word address (addr[1:0]=0), byte strobes, aligned write data.
REQ-013 drsp_valid / drsp_rdata  in  1/32  load response, one pulse per load.
REQ-014 wb_valid / wb_pc / wb_wd / wb_wreg / wb_wdata  out  1/32/5/1/32  registered result to MEM/WB.
REQ-015 wb_ale  out  1  address-misalignment exception flag for wb instruction.

Function
REQ-016 FSM states IDLE, REQ, WAIT; only IDLE samples in_*.
REQ-017 IDLE, in_valid=0: next edge wb_valid=0, wb_ale=0, other wb_* hold.
REQ-018 IDLE, valid non-memory op: next edge wb_* = in_*, wb_valid=1, wb_ale=0; latency 1, stall_req=0.
REQ-019 Misalignment: H ops with addr[0]=1, W ops with addr[1:0]!=0; in IDLE -> no request, next edge wb_valid=1, wb_wreg=0, wb_ale=1, wb_pc=in_pc, stall_req=0.
REQ-020 IDLE, valid aligned memory op: stall_req=1 combinationally, capture in_* into internal regs, next state REQ.
REQ-021 REQ: dreq_valid=1, fields from captured regs, stable until dreq_ready; stall_req=1.
REQ-022 Store handshake (dreq_valid&dreq_ready, we=1): stall_req=0 that cycle; next edge wb_valid=1, wb_wreg=0, state IDLE.
REQ-023 Load handshake: next state WAIT, dreq_valid=0; drsp_valid in handshake cycle ignored.
REQ-024 WAIT: stall_req=1 until drsp_valid; in drsp_valid cycle stall_req=0, next edge wb_valid=1, wb_wreg=captured wreg, wb_wdata=aligned load data, state IDLE.
REQ-025 Load align: byte = rdata[8*addr[1:0]+:8], half = rdata[16*addr[1]+:16]; LD_B/LD_H sign-extend, LD_BU/LD_HU zero-extend, LD_W unchanged.
REQ-026 Store: ST_B wstrb=4'b0001<<addr[1:0], wdata={4{reg2[7:0]}}; ST_H wstrb=4'b0011<<{addr[1],1'b0}, wdata={2{reg2[15:0]}}; ST_W 4'b1111, reg2.
REQ-027 Loads drive dreq_we=0, dreq_wstrb=0.
REQ-028 In REQ/WAIT, wb_valid=0 each cycle until completion; held in_* never re-accepted.
REQ-029 drsp_valid in IDLE or REQ SHALL be ignored.
REQ-030 Back-to-back: instruction presented in completion cycle's following cycle is accepted normally (no bubble beyond REQ-018/020 rules).

Reset
REQ-031 rst low: state=IDLE, all outputs 0 (dreq_valid, stall_req, wb_*, wb_ale) immediately, without clock.
REQ-032 Reset mid-REQ/WAIT abandons transaction; late drsp_valid after release ignored.

Verification
REQ-033 Non-memory op pc=0x1C000000, wd=5, wdata=0x1234 -> next edge wb_valid=1, wb_wdata=0x1234, stall_req=0.
REQ-034 ST_B addr=0x103, reg2=0xAB, dreq_ready 2 cycles late -> dreq_wstrb=4'b1000, wdata=0xABABABAB held stable, wb_wreg=0 after handshake.
REQ-035 LD_B addr=0x102, rdata=0x00800000 after 3-cycle wait -> wb_wdata=0xFFFFFF80; LD_BU same -> 0x00000080; stall_req high throughout.
REQ-036 LD_W addr=0x102 -> no dreq_valid, wb_ale=1, wb_wreg=0, one cycle.
REQ-037 rst low during WAIT, then drsp_valid after release -> all outputs 0, response ignored, next op processed normally.
